xbar_port_arbiter: RTL and testbench
====================================

Name: xbar_port_arbiter

Overview:
- Packet-locking round-robin arbiter for one crossbar output port.
- Shares the output port between NUM_REQ input requesters.
- Once a requester is granted, the grant is held until that requester's last flit transfers; the next grant is then chosen round-robin.
- Priority rotation uses a thermometer mask derived from the previous grant, so the last winner has lowest priority.

Parameters:
- NUM_REQ, 4, number of requesting input ports (>=2).
- TIMEOUT, 16, stall-cycle limit before forced release; used only with XBAR_ARB_TIMEOUT_EN; width = clog2(TIMEOUT+1).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  NUM_REQ  per-requester flit valid / request
- in_last  input  NUM_REQ  per-requester last-flit-of-packet flag
- in_ready  output  NUM_REQ  per-requester ready; = grant & {NUM_REQ{out_ready}} (combinational)
- out_valid  output  1  |(in_valid & grant) (combinational)
- out_last  output  1  |(in_last & grant) (combinational)
- out_ready  input  1  downstream ready
- grant  output  NUM_REQ  registered one-hot grant; all-zero when idle
- busy  output  1  registered; 1 while a packet is locked (state LOCKED)
- timeout_err  output  1  one-cycle pulse on forced release (tied 0 without macro)

Behaviour:
- Reset (sync, rst=1 at posedge):
  - grant=0, busy=0, timeout_err=0, state=IDLE.
  - last_grant pointer = one-hot bit NUM_REQ-1, so the first arbitration favours requester 0.
- Priority mask: pmask = bits strictly above the last_grant bit.
  - Example: last_grant=0010 gives pmask=1100.
  - Winner = lowest set bit of (in_valid & pmask) if nonzero, else lowest set bit of in_valid.
- Transfer: xfer = out_valid & out_ready. Release condition: rel = xfer & out_last.
- States: IDLE, LOCKED.
  - IDLE: if in_valid!=0 at the edge, grant<=winner, last_grant<=winner, goto LOCKED. Grant appears one cycle after the request is seen; no transfer occurs in the request cycle. Otherwise stay IDLE, grant=0.
  - LOCKED: grant held constant. If the granted in_valid drops mid-packet, grant is still held (packet lock); no other requester can intrude.
  - LOCKED with rel=1: re-arbitrate in the same edge, using the updated pmask (the current holder now has lowest priority). If the winner exists, grant<=winner and stay LOCKED, giving back-to-back packets with zero bubble. If no other request and the holder is also not valid, grant<=0 and goto IDLE. The holder may win again only if it is the sole valid requester.
- Single-flit packet (in_last=1 on the first flit): released on that transfer.
- rst asserted mid-packet: immediate return to reset values next edge; the partial packet is abandoned; no special handling.
- busy = (state==LOCKED); grant is nonzero iff busy.
- Changes in in_valid of non-granted requesters while LOCKED have no effect.

Optional Feature:
- Macro: XBAR_ARB_TIMEOUT_EN.
- Defined:
  - Stall counter cnt increments each LOCKED cycle without xfer; resets to 0 on xfer or on leaving LOCKED.
  - When cnt reaches TIMEOUT, force release exactly as if rel=1 (re-arbitrate with rotated priority) and pulse timeout_err for 1 cycle.
  - cnt resets to 0 on rst.
- Undefined: no counter logic; timeout_err tied 0; grant held indefinitely until rel.

Test Plan:
- Post-reset, in_valid=0101, out_ready=1, every flit last → grant sequence 0001, 0100, 0001, 0100 (one per cycle after first), no idle bubble between grants.
- in_valid=1111, 3-flit packets (in_last on 3rd flit), out_ready=1 → grants rotate 0001→0010→0100→1000→0001, each held exactly 3 cycles.
- Requester 1 granted and sends flit 1 of 3, then in_valid[1]=0 for 5 cycles while in_valid[2]=1 → grant stays 0010, in_ready[2]=0 throughout; flits resume and release → grant 0100.
- out_ready=0 for 4 cycles mid-packet → grant unchanged, in_ready=0; with out_ready=1 packet completes and releases normally.
- rst=1 while locked on requester 2 → next cycle grant=0, busy=0; after rst, in_valid=1100 → grant 0100 (pointer reset).
- With XBAR_ARB_TIMEOUT_EN, TIMEOUT=16, holder stalls (in_valid=0) 16 cycles with in_valid[3]=1 → timeout_err pulses once, grant moves to 1000; without the macro the grant stays on the holder.

Source files
------------

// File: rtl/xbar_port_arbiter.sv
// Packet-locking round-robin arbiter for one crossbar output port.
// Optional stall-timeout release is enabled with `define XBAR_ARB_TIMEOUT_EN.
module xbar_port_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] in_valid,
  input  logic [NUM_REQ-1:0] in_last,
  output logic [NUM_REQ-1:0] in_ready,
  output logic               out_valid,
  output logic               out_last,
  input  logic               out_ready,
  output logic [NUM_REQ-1:0] grant,
  output logic               busy,
  output logic               timeout_err
);

  typedef enum logic [0:0] {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);
  localparam logic [NUM_REQ-1:0] TOP = ONE << (NUM_REQ - 1);

  state_t             state_r, state_n;
  logic [NUM_REQ-1:0] grant_r, grant_n;
  logic [NUM_REQ-1:0] last_grant_r, last_grant_n;
  logic               busy_r;
  logic [NUM_REQ-1:0] pmask_s, masked_s, winner_s;
  logic               xfer_s, rel_s, fire_s, release_s;

  function automatic logic [NUM_REQ-1:0] lowest_bit(input logic [NUM_REQ-1:0] v);
    return v & (~v + ONE);
  endfunction

  // Last winner gets lowest priority: only bits strictly above it are favoured
  assign pmask_s   = ~(last_grant_r | (last_grant_r - ONE));
  assign masked_s  = in_valid & pmask_s;
  assign winner_s  = (masked_s != {NUM_REQ{1'b0}}) ? lowest_bit(masked_s) : lowest_bit(in_valid);

  assign in_ready  = grant_r & {NUM_REQ{out_ready}};
  assign out_valid = |(in_valid & grant_r);
  assign out_last  = |(in_last & grant_r);
  assign xfer_s    = out_valid & out_ready;
  assign rel_s     = xfer_s & out_last;
  assign release_s = rel_s | fire_s;

  assign grant     = grant_r;
  assign busy      = busy_r;

`ifdef XBAR_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_r;
  logic          timeout_err_r;

  assign fire_s      = (state_r == LOCKED) && !xfer_s && (cnt_r == CW'(TIMEOUT));
  assign timeout_err = timeout_err_r;

  // Stall counter and one-cycle timeout pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r         <= {CW{1'b0}};
      timeout_err_r <= 1'b0;
    end else begin
      timeout_err_r <= fire_s;
      if ((state_r != LOCKED) || xfer_s || fire_s) begin
        cnt_r <= {CW{1'b0}};
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end
`else
  assign fire_s      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Next-state and next-grant decode
  always_comb begin
    state_n      = state_r;
    grant_n      = grant_r;
    last_grant_n = last_grant_r;
    case (state_r)
      IDLE: begin
        if (in_valid != {NUM_REQ{1'b0}}) begin
          grant_n      = winner_s;
          last_grant_n = winner_s;
          state_n      = LOCKED;
        end else begin
          grant_n = {NUM_REQ{1'b0}};
        end
      end
      LOCKED: begin
        if (release_s && (in_valid != {NUM_REQ{1'b0}})) begin
          grant_n      = winner_s;
          last_grant_n = winner_s;
        end else if (release_s) begin
          grant_n = {NUM_REQ{1'b0}};
          state_n = IDLE;
        end else begin
          grant_n = grant_r;
        end
      end
      default: begin
        grant_n = {NUM_REQ{1'b0}};
        state_n = IDLE;
      end
    endcase
  end

  // State, grant, pointer and busy registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      grant_r      <= {NUM_REQ{1'b0}};
      last_grant_r <= TOP;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_n;
      grant_r      <= grant_n;
      last_grant_r <= last_grant_n;
      busy_r       <= (state_n == LOCKED);
    end
  end

endmodule

// File: tb/tb_xbar_port_arbiter.sv
// Directed self-checking bench for xbar_port_arbiter (NUM_REQ=4, TIMEOUT=16).
module tb_xbar_port_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_valid, in_last, in_ready, grant;
  logic       out_valid, out_last, out_ready, busy, timeout_err;

  int checks_r = 0;
  int passed_r = 0;

  xbar_port_arbiter #(.NUM_REQ(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .grant(grant), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks_r++;
    if (act === exp) begin
      passed_r++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 4'b0000;
    in_last = 4'b0000;
    out_ready = 1'b1;
    step();
    rst = 1'b0;
  endtask

  logic [3:0] exp_seq[5];
  int         seen;

  initial begin
    rst = 1'b1; in_valid = 4'b0000; in_last = 4'b0000; out_ready = 1'b1;
    step();
    do_reset();
    chk("rst_grant", grant, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_terr", timeout_err, 1'b0);
    chk("rst_oval", out_valid, 1'b0);

    // Single-flit packets from requesters 0 and 2: alternate with no bubble
    in_valid = 4'b0101; in_last = 4'b1111;
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0100; exp_seq[2] = 4'b0001; exp_seq[3] = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("alt_grant%0d", i), grant, exp_seq[i]);
      chk($sformatf("alt_ready%0d", i), in_ready, exp_seq[i]);
      chk($sformatf("alt_busy%0d", i), busy, 1'b1);
    end

    // Four requesters, 3-flit packets: full rotation, each held 3 cycles
    do_reset();
    in_valid = 4'b1111; in_last = 4'b0000;
    step();
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
    exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;
    for (int p = 0; p < 5; p++) begin
      for (int b = 0; b < 3; b++) begin
        in_last = (b == 2) ? 4'b1111 : 4'b0000;
        #1;
        chk($sformatf("rot_p%0d_b%0d", p, b), grant, exp_seq[p]);
        chk($sformatf("rot_olast_p%0d_b%0d", p, b), out_last, (b == 2) ? 1'b1 : 1'b0);
        step();
      end
    end

    // Holder 1 drops valid mid-packet; requester 2 cannot intrude
    do_reset();
    in_valid = 4'b0010; in_last = 4'b0000;
    step();
    chk("lock_grant", grant, 4'b0010);
    step();
    in_valid = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("lock_hold%0d", i), grant, 4'b0010);
      chk($sformatf("lock_ready%0d", i), in_ready, 4'b0010);
      chk($sformatf("lock_oval%0d", i), out_valid, 1'b0);
      step();
    end
    in_valid = 4'b0110;
    step();
    in_last = 4'b0010;
    #1;
    chk("lock_lastflit", grant, 4'b0010);
    step();
    chk("lock_next", grant, 4'b0100);

    // Downstream stall mid-packet on holder 2
    in_last = 4'b0000; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("stall_grant%0d", i), grant, 4'b0100);
      chk($sformatf("stall_ready%0d", i), in_ready, 4'b0000);
    end
    out_ready = 1'b1;
    step();
    in_last = 4'b0100;
    #1;
    chk("stall_resume", grant, 4'b0100);
    step();
    chk("stall_release", grant, 4'b0010);

    // Reset while locked on requester 2; pointer returns to favour requester 0
    do_reset();
    in_valid = 4'b0100;
    step();
    chk("rlk_grant", grant, 4'b0100);
    rst = 1'b1;
    step();
    chk("rlk_grant0", grant, 4'b0000);
    chk("rlk_busy0", busy, 1'b0);
    rst = 1'b0; in_valid = 4'b1100;
    step();
    chk("rlk_ptr", grant, 4'b0100);

    // Holder stalls with requester 3 waiting
    in_valid = 4'b1000;
`ifdef XBAR_ARB_TIMEOUT_EN
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (timeout_err) begin
        seen++;
        chk("tmo_grant", grant, 4'b1000);
      end
    end
    chk("tmo_pulses", seen, 1);
`else
    seen = 0;
    for (int i = 0; i < 24; i++) begin
      step();
      if (timeout_err) seen++;
    end
    chk("tmo_hold", grant, 4'b0100);
    chk("tmo_none", seen, 0);
`endif

    $display("%0d/%0d checks passed", passed_r, checks_r);
    $finish;
  end

endmodule
